matrix_uop_sequencer: RTL and testbench
=======================================

// Module: matrix_uop_sequencer
// PURPOSE
//  Multi-cycle successor to the single-cycle matrix control decode, located in the ID stage.
//  It accepts one matrix instruction at a time and decodes it from opcode and funct3.
//  Each instruction is expanded into a row-by-row stream of micro-ops (uops) for the matrix unit.
//  The front end is stalled until the whole stream has been issued.
//  Non-matrix instructions pass straight through and are ignored by this block.
// PARAMETERS
//  ROWS        4            matrix rows; number of uops for row ops (>=1)
//  ADDR_W      32           address/operand width
//  MAT_OPCODE  7'b0001011   inst[6:0] value that marks a matrix instruction
//  RW          $clog2(ROWS), min 1 (localparam) - row index width
// PORTS
//  clk         in   1       clock
//  rst         in   1       async reset, active-high
//  id_valid    in   1       instruction present in ID
//  id_inst     in   32      instruction word
//  id_ready    out  1       block can accept a matrix instruction
//  rs1_val     in   ADDR_W  base address / scalar operand
//  rs2_val     in   ADDR_W  row stride in bytes
//  flush       in   1       pipeline flush (branch/exception)
//  stall       out  1       hold IF/ID
//  uop_valid   out  1       uop present
//  uop_ready   in   1       matrix unit accepts uop
//  uop_kind    out  3       funct3 of the active instruction
//  uop_row     out  RW      row index of the current uop
//  uop_addr    out  ADDR_W  rs1_val + uop_row*rs2_val (mod 2^ADDR_W)
//  uop_last    out  1       final uop of the instruction
//  done        out  1       1-cycle pulse after the last uop handshake
//  illegal     out  1       1-cycle pulse for an undefined funct3
// BEHAVIOUR
//  - is_mat = id_valid & (id_inst[6:0]==MAT_OPCODE). funct3 decode:
//    000 MLOAD, 001 MSTORE, 100 MOPA: ROWS uops each.
//    010 MMV2R, 011 MR2MV: one uop, row 0.
//    Other funct3 values are illegal.
//  - FSM states IDLE, ISSUE, DONE.
//    - IDLE: id_ready=1. On is_mat with a legal funct3, latch funct3, rs1_val and rs2_val, set row=0 -> ISSUE.
//    - IDLE, illegal funct3: illegal=1 next cycle, no uops, stay IDLE.
//    - ISSUE: uop_valid=1. On uop_valid&uop_ready: if uop_last -> DONE, else row+1.
//    - DONE: done=1 for one cycle -> IDLE.
//  - Latency: accepted at cycle T -> first uop_valid at T+1.
//    ROWS-uop op with uop_ready held high: done at T+ROWS+1.
//  - Handshake: uop_kind, uop_row, uop_addr and uop_last are stable while uop_valid & !uop_ready.
//    uop_valid never drops without a handshake, except on flush or rst.
//  - stall = is_mat | (state!=IDLE). Non-matrix instructions: stall=0, no state change.
//  - uop_addr is registered and updated incrementally: addr += stride per handshake.
//    Wraps modulo 2^ADDR_W; no overflow flag.
//  - uop_last = (row==ROWS-1) for row ops; always 1 for single-uop ops.
//  - flush: next state IDLE, uop_valid=0 next cycle, no done pulse.
//    - flush and a handshake in the same cycle: the uop counts as delivered, flush still wins.
//    - flush in IDLE with is_mat: the instruction is not accepted.
//  - rst mid-operation: immediate return to IDLE, stream abandoned.
//  - Reset values: state=IDLE, uop_valid=0, uop_kind=0, uop_row=0, uop_addr=0, uop_last=0, done=0, illegal=0.
//    id_ready=1; stall follows is_mat (combinational).
//  - ROWS=1: MLOAD issues a single uop with uop_last=1.
// CONFIGURATION
//  - MATRIX_SEQ_PERF_EN defined: adds output ports perf_uops[31:0] and perf_stall[31:0].
//    - perf_uops counts uop handshakes.
//    - perf_stall counts cycles with stall=1.
//    - Both wrap at 2^32 and clear on rst only.
//  - Not defined: those ports and counters do not exist; all other behaviour is identical.
// TESTING
//  - MLOAD, ROWS=4, rs1=0x1000, rs2=0x10, uop_ready=1 -> 4 uops.
//    Addr 0x1000/0x1010/0x1020/0x1030, rows 0-3, uop_last on row 3, done at T+5.
//  - MSTORE with uop_ready low for 3 cycles on row 1 -> row 1 fields held stable.
//    Total 4 handshakes, done after the 4th.
//  - MMV2R -> one uop, row 0, uop_last=1, done at T+2. Then a non-matrix inst -> stall=0, no uop.
//  - MOPA with flush asserted at row 2 -> uop_valid=0 next cycle, no done.
//    Next MLOAD restarts at row 0.
//  - funct3=111 -> illegal pulse, no uop_valid. rst during ISSUE -> all outputs at reset values.
//  - rs1=0xFFFFFFF8, rs2=8 -> uop_addr 0xFFFFFFF8, 0x0, 0x8, 0x10 (wrap).
//    With MATRIX_SEQ_PERF_EN defined, perf_uops increments by 4.

Source files
------------

// File: rtl/matrix_uop_sequencer.sv
// matrix_uop_sequencer: decodes one matrix instruction in ID and expands it
// into a row-by-row micro-op stream for the matrix unit, stalling IF/ID until
// the whole stream has been issued.
// Optional build macro: MATRIX_SEQ_PERF_EN adds perf_uops / perf_stall counters.
module matrix_uop_sequencer #(
  parameter int unsigned ROWS       = 4,
  parameter int unsigned ADDR_W     = 32,
  parameter logic [6:0]  MAT_OPCODE = 7'b0001011,
  localparam int unsigned RW        = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [31:0]       id_inst,
  output logic              id_ready,
  input  logic [ADDR_W-1:0] rs1_val,
  input  logic [ADDR_W-1:0] rs2_val,
  input  logic              flush,
  output logic              stall,
  output logic              uop_valid,
  input  logic              uop_ready,
  output logic [2:0]        uop_kind,
  output logic [RW-1:0]     uop_row,
  output logic [ADDR_W-1:0] uop_addr,
  output logic              uop_last,
  output logic              done,
  output logic              illegal
`ifdef MATRIX_SEQ_PERF_EN
  ,
  output logic [31:0]       perf_uops,
  output logic [31:0]       perf_stall
`endif
);

  localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   stride_q, stride_d;
  logic                valid_d;
  logic [2:0]          kind_d;
  logic [RW-1:0]       row_d;
  logic [ADDR_W-1:0]   addr_d;
  logic                last_d;
  logic                done_d;
  logic                illegal_d;

  logic                is_mat;
  logic [2:0]          funct3;
  logic                row_op;
  logic                single_op;
  logic                handshake;
  logic                unused_inst;

  // Instruction decode from opcode and funct3
  assign is_mat    = id_valid & (id_inst[6:0] == MAT_OPCODE);
  assign funct3    = id_inst[14:12];
  assign row_op    = (funct3 == 3'b000) | (funct3 == 3'b001) | (funct3 == 3'b100);
  assign single_op = (funct3 == 3'b010) | (funct3 == 3'b011);
  assign handshake = uop_valid & uop_ready;
  assign unused_inst = ^{id_inst[31:15], id_inst[11:7]};

  // Front-end handshake: accept only when idle, hold IF/ID while busy or decoding
  assign id_ready = (state_q == ST_IDLE);
  assign stall    = is_mat | (state_q != ST_IDLE);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d   = state_q;
    stride_d  = stride_q;
    valid_d   = uop_valid;
    kind_d    = uop_kind;
    row_d     = uop_row;
    addr_d    = uop_addr;
    last_d    = uop_last;
    done_d    = 1'b0;
    illegal_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (is_mat && !flush) begin
          if (row_op || single_op) begin
            state_d  = ST_ISSUE;
            valid_d  = 1'b1;
            kind_d   = funct3;
            row_d    = '0;
            addr_d   = rs1_val;
            stride_d = rs2_val;
            last_d   = single_op | (ROW_LAST == '0);
          end else begin
            illegal_d = 1'b1;
          end
        end
      end
      ST_ISSUE: begin
        if (flush) begin
          // A uop handshaking alongside flush is still delivered; flush wins on state
          state_d = ST_IDLE;
          valid_d = 1'b0;
        end else if (handshake) begin
          if (uop_last) begin
            state_d = ST_DONE;
            valid_d = 1'b0;
            done_d  = 1'b1;
          end else begin
            row_d  = uop_row + RW'(1);
            addr_d = uop_addr + stride_q;
            last_d = (row_d == ROW_LAST);
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  // Registered uop outputs and latched stride
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stride_q  <= '0;
      uop_valid <= 1'b0;
      uop_kind  <= 3'b000;
      uop_row   <= '0;
      uop_addr  <= '0;
      uop_last  <= 1'b0;
      done      <= 1'b0;
      illegal   <= 1'b0;
    end else begin
      stride_q  <= stride_d;
      uop_valid <= valid_d;
      uop_kind  <= kind_d;
      uop_row   <= row_d;
      uop_addr  <= addr_d;
      uop_last  <= last_d;
      done      <= done_d;
      illegal   <= illegal_d;
    end
  end

`ifdef MATRIX_SEQ_PERF_EN
  // Free-running handshake and stall-cycle counters, cleared only by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_uops  <= 32'd0;
      perf_stall <= 32'd0;
    end else begin
      if (handshake) perf_uops <= perf_uops + 32'd1;
      if (stall)     perf_stall <= perf_stall + 32'd1;
    end
  end
`else
  // Performance counters are not built in this configuration
`endif

endmodule

// File: tb/tb_matrix_uop_sequencer.sv
// Testbench for matrix_uop_sequencer: a queue-based model of the expected uop
// stream is checked every cycle, alongside directed scenarios with literal
// expectations. Optional build macro: MATRIX_SEQ_PERF_EN.
module tb_matrix_uop_sequencer;

  localparam int unsigned ROWS = 4;
  localparam int unsigned BRW  = 2;
  localparam logic [6:0]  MATOP = 7'b0001011;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            id_valid = 1'b0;
  logic [31:0]     id_inst = 32'd0;
  logic            id_ready;
  logic [31:0]     rs1_val = 32'd0;
  logic [31:0]     rs2_val = 32'd0;
  logic            flush = 1'b0;
  logic            stall;
  logic            uop_valid;
  logic            uop_ready = 1'b1;
  logic [2:0]      uop_kind;
  logic [BRW-1:0]  uop_row;
  logic [31:0]     uop_addr;
  logic            uop_last;
  logic            done;
  logic            illegal;
`ifdef MATRIX_SEQ_PERF_EN
  logic [31:0]     perf_uops;
  logic [31:0]     perf_stall;
`endif

  matrix_uop_sequencer #(.ROWS(ROWS), .ADDR_W(32), .MAT_OPCODE(MATOP)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_inst(id_inst), .id_ready(id_ready),
    .rs1_val(rs1_val), .rs2_val(rs2_val),
    .flush(flush), .stall(stall),
    .uop_valid(uop_valid), .uop_ready(uop_ready),
    .uop_kind(uop_kind), .uop_row(uop_row), .uop_addr(uop_addr),
    .uop_last(uop_last), .done(done), .illegal(illegal)
`ifdef MATRIX_SEQ_PERF_EN
    , .perf_uops(perf_uops), .perf_stall(perf_stall)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: the instruction becomes a list of pending uops; handshakes consume it
  typedef struct {
    logic [BRW-1:0] row;
    logic [31:0]    addr;
    logic           last;
  } uop_t;

  uop_t        q[$];
  uop_t        hs_log[$];
  logic [2:0]  m_kind = 3'b000;
  logic        m_done = 1'b0;
  logic        m_ill  = 1'b0;
  logic        m_nd, m_ni;
  int          m_n;
  logic [31:0] m_uops = 32'd0;
  logic [31:0] m_stall = 32'd0;

  function automatic logic mat_in();
    return id_valid && (id_inst[6:0] == MATOP);
  endfunction

  function automatic logic busy();
    return (q.size() > 0) || m_done;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      m_done  = 1'b0;
      m_ill   = 1'b0;
      m_uops  = 32'd0;
      m_stall = 32'd0;
    end else begin
      m_nd = 1'b0;
      m_ni = 1'b0;
      if (mat_in() || busy()) m_stall = m_stall + 32'd1;
      if (q.size() > 0) begin
        if (uop_ready) m_uops = m_uops + 32'd1;
        if (flush) q.delete();
        else if (uop_ready) begin
          if (q[0].last) m_nd = 1'b1;
          void'(q.pop_front());
        end
      end else if (!m_done && mat_in() && !flush) begin
        m_n = 0;
        case (id_inst[14:12])
          3'b000, 3'b001, 3'b100: m_n = ROWS;
          3'b010, 3'b011:         m_n = 1;
          default:                m_ni = 1'b1;
        endcase
        m_kind = id_inst[14:12];
        for (int i = 0; i < m_n; i++)
          q.push_back('{row: BRW'(i), addr: rs1_val + 32'(i) * rs2_val, last: (i == m_n - 1)});
      end
      m_done = m_nd;
      m_ill  = m_ni;
    end
  end

  // Per-cycle compare against the model, and a log of delivered uops
  always begin
    @(negedge clk);
    #3;
    if (!rst) begin
      chk("uop_valid", 32'(uop_valid), 32'(q.size() > 0));
      chk("done", 32'(done), 32'(m_done));
      chk("illegal", 32'(illegal), 32'(m_ill));
      chk("id_ready", 32'(id_ready), 32'(!busy()));
      chk("stall", 32'(stall), 32'(mat_in() || busy()));
      if (q.size() > 0) begin
        chk("uop_kind", 32'(uop_kind), 32'(m_kind));
        chk("uop_row", 32'(uop_row), 32'(q[0].row));
        chk("uop_addr", uop_addr, q[0].addr);
        chk("uop_last", 32'(uop_last), 32'(q[0].last));
      end
`ifdef MATRIX_SEQ_PERF_EN
      chk("perf_uops", perf_uops, m_uops);
      chk("perf_stall", perf_stall, m_stall);
`endif
      if (uop_valid && uop_ready)
        hs_log.push_back('{row: uop_row, addr: uop_addr, last: uop_last});
    end
  end

  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [6:0] op);
    @(negedge clk);
    id_valid = 1'b1;
    id_inst  = {17'd0, f3, 5'd0, op};
    rs1_val  = a;
    rs2_val  = b;
    @(posedge clk);
    #1;
    id_valid = 1'b0;
    id_inst  = 32'd0;
  endtask

  // Counts cycles from acceptance (T+1 = 1) until done is seen, bounded
  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(negedge clk);
      #3;
      n++;
    end while (!done && n < 40);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_uop_valid"}, 32'(uop_valid), 32'd0);
    chk({tag, "_uop_kind"}, 32'(uop_kind), 32'd0);
    chk({tag, "_uop_row"}, 32'(uop_row), 32'd0);
    chk({tag, "_uop_addr"}, uop_addr, 32'd0);
    chk({tag, "_uop_last"}, 32'(uop_last), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_illegal"}, 32'(illegal), 32'd0);
    chk({tag, "_id_ready"}, 32'(id_ready), 32'd1);
    chk({tag, "_stall"}, 32'(stall), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [31:0] exp_a[4];
    logic [31:0] p0;
    p0 = 32'd0;

    // Reset state
    repeat (2) @(negedge clk);
    #3;
    chk_reset_vals("reset");
    @(negedge clk);
    #1 rst = 1'b0;

    // MLOAD, 4 uops back-to-back, done at T+5
    hs_log.delete();
    issue(3'b000, 32'h1000, 32'h10, MATOP);
    wait_done(n);
    chk("mload_done_lat", 32'(n), 32'd5);
    chk("mload_count", 32'(hs_log.size()), 32'd4);
    exp_a = '{32'h1000, 32'h1010, 32'h1020, 32'h1030};
    for (int i = 0; i < 4 && i < hs_log.size(); i++) begin
      chk("mload_row", 32'(hs_log[i].row), 32'(i));
      chk("mload_addr", hs_log[i].addr, exp_a[i]);
      chk("mload_last", 32'(hs_log[i].last), 32'(i == 3));
    end

    // MSTORE with back-pressure on row 1 for 3 cycles
    hs_log.delete();
    issue(3'b001, 32'h3000, 32'h20, MATOP);
    @(negedge clk);
    @(negedge clk);
    uop_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      #3;
      chk("mstore_hold_valid", 32'(uop_valid), 32'd1);
      chk("mstore_hold_row", 32'(uop_row), 32'd1);
      chk("mstore_hold_addr", uop_addr, 32'h3020);
      chk("mstore_hold_kind", 32'(uop_kind), 32'd1);
      chk("mstore_hold_last", 32'(uop_last), 32'd0);
    end
    @(negedge clk);
    uop_ready = 1'b1;
    wait_done(n);
    chk("mstore_done", 32'(done), 32'd1);
    chk("mstore_count", 32'(hs_log.size()), 32'd4);

    // MMV2R: single uop, done at T+2
    hs_log.delete();
    issue(3'b010, 32'h4000, 32'h8, MATOP);
    wait_done(n);
    chk("mmv2r_done_lat", 32'(n), 32'd2);
    chk("mmv2r_count", 32'(hs_log.size()), 32'd1);
    if (hs_log.size() > 0) begin
      chk("mmv2r_row", 32'(hs_log[0].row), 32'd0);
      chk("mmv2r_last", 32'(hs_log[0].last), 32'd1);
      chk("mmv2r_addr", hs_log[0].addr, 32'h4000);
    end

    // Non-matrix instruction passes through
    @(negedge clk);
    id_valid = 1'b1;
    id_inst  = 32'h0000_0033;
    #2;
    chk("nonmat_stall", 32'(stall), 32'd0);
    chk("nonmat_ready", 32'(id_ready), 32'd1);
    @(posedge clk);
    #1 id_valid = 1'b0;
    id_inst = 32'd0;
    @(negedge clk);
    #3;
    chk("nonmat_no_uop", 32'(uop_valid), 32'd0);

    // MOPA flushed while row 2 is handshaking
    hs_log.delete();
    issue(3'b100, 32'h2000, 32'h4, MATOP);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(uop_valid && uop_row == 2'd2) && n < 10);
    chk("mopa_reach_row2", 32'(n < 10), 32'd1);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    #3;
    chk("flush_valid_low", 32'(uop_valid), 32'd0);
    chk("flush_delivered", 32'(hs_log.size()), 32'd3);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #3;
      chk("flush_no_done", 32'(done), 32'd0);
    end
    hs_log.delete();
    issue(3'b000, 32'h500, 32'h4, MATOP);
    wait_done(n);
    chk("restart_count", 32'(hs_log.size()), 32'd4);
    if (hs_log.size() > 0) begin
      chk("restart_row0", 32'(hs_log[0].row), 32'd0);
      chk("restart_addr0", hs_log[0].addr, 32'h500);
    end

    // Undefined funct3 pulses illegal, issues nothing
    issue(3'b111, 32'h1, 32'h1, MATOP);
    @(negedge clk);
    #3;
    chk("illegal_pulse", 32'(illegal), 32'd1);
    chk("illegal_no_uop", 32'(uop_valid), 32'd0);
    @(negedge clk);
    #3;
    chk("illegal_one_cycle", 32'(illegal), 32'd0);

    // Reset in the middle of a stalled MSTORE
    uop_ready = 1'b0;
    issue(3'b001, 32'hABC0, 32'h10, MATOP);
    repeat (2) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk_reset_vals("midrst");
`ifdef MATRIX_SEQ_PERF_EN
    chk("midrst_perf_uops", perf_uops, 32'd0);
    chk("midrst_perf_stall", perf_stall, 32'd0);
`endif
    @(negedge clk);
    #1 rst = 1'b0;
    uop_ready = 1'b1;

    // Address wraps modulo 2^32
    hs_log.delete();
`ifdef MATRIX_SEQ_PERF_EN
    p0 = perf_uops;
`endif
    issue(3'b000, 32'hFFFF_FFF8, 32'h8, MATOP);
    wait_done(n);
    chk("wrap_count", 32'(hs_log.size()), 32'd4);
    exp_a = '{32'hFFFF_FFF8, 32'h0, 32'h8, 32'h10};
    for (int i = 0; i < 4 && i < hs_log.size(); i++)
      chk("wrap_addr", hs_log[i].addr, exp_a[i]);
`ifdef MATRIX_SEQ_PERF_EN
    chk("wrap_perf_delta", perf_uops - p0, 32'd4);
`endif
    chk("wrap_p0_unused", p0 & 32'd0, 32'd0 & p0);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
